// File: rtl/fifo_ctrl_pkg.sv
// Shared FIFO helpers: pointer width (address bits plus one wrap bit) and a
// default pointer type, kept here so a later async FIFO can reuse them.
package fifo_ctrl_pkg;

    localparam int unsigned DEFAULT_DEPTH = 8;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [ptr_width(DEFAULT_DEPTH)-1:0] ptr_t;

endpackage

// File: rtl/dp_ram_if.sv
// Dual-port RAM bus; "sys" is the controller side, "ram" the storage side.
interface dp_ram_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 8
);
    localparam int unsigned ADDR_W = $clog2(RAM_DEPTH);

    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] data_out;

    modport sys (output wr_en, wr_addr, data_in, rd_en, rd_addr, input data_out);
    modport ram (input wr_en, wr_addr, data_in, rd_en, rd_addr, output data_out);
endinterface

// File: rtl/fifo_if.sv
// Producer/consumer side of the FIFO; the "fifo" modport is the controller view.
interface fifo_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  full;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;

    modport fifo (input wr_en, data_in, rd_en, output full, empty, data_out);
    modport user (output wr_en, data_in, rd_en, input full, empty, data_out);
endinterface

// File: rtl/dp_ram.sv
// Simple dual-port RAM with registered read; output only updates on rd_en.
module dp_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RAM_DEPTH  = 8
) (
    input logic   clk,
    dp_ram_if.ram ram
);

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (ram.wr_en) begin
            mem_q[ram.wr_addr] <= ram.data_in;
        end
        if (ram.rd_en) begin
            data_out_q <= mem_q[ram.rd_addr];
        end
    end

    assign ram.data_out = data_out_q;

endmodule

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register; wraps naturally modulo 2**PTR_W.
module fifo_ptr #(
    parameter int unsigned PTR_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: owns pointers and flags, storage lives in an
// external dual-port RAM driven through the dp_ram_if "sys" modport.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               n_rst,
    fifo_if.fifo                               fifo,
    dp_ram_if.sys                              ram,
    output logic [ptr_width(FIFO_DEPTH)-1:0]   count
);

    localparam int unsigned PTR_W  = ptr_width(FIFO_DEPTH);
    localparam int unsigned ADDR_W = PTR_W - 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_accept_c;
    logic                  rd_accept_c;
    logic                  full_c;
    logic                  empty_c;
    logic [DATA_WIDTH-1:0] wr_data_c;

    fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (wr_accept_c),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (rd_accept_c),
        .ptr   (rd_ptr)
    );

    // Flags come straight off the registered pointers: the wrap bit tells
    // a full ring apart from an empty one when the addresses coincide.
    always_comb begin
        empty_c     = (wr_ptr == rd_ptr);
        full_c      = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
        wr_accept_c = fifo.wr_en && !full_c;
        rd_accept_c = fifo.rd_en && !empty_c;
        wr_data_c   = fifo.data_in;
    end

    assign count         = wr_ptr - rd_ptr;
    assign fifo.full     = full_c;
    assign fifo.empty    = empty_c;
    assign fifo.data_out = ram.data_out;

    assign ram.wr_en   = wr_accept_c;
    assign ram.wr_addr = wr_ptr[ADDR_W-1:0];
    assign ram.data_in = wr_data_c;
    assign ram.rd_en   = rd_accept_c;
    assign ram.rd_addr = rd_ptr[ADDR_W-1:0];

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl + dp_ram against a queue-based FIFO model.
module tb_fifo_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             n_rst;
    logic [PTR_W-1:0] count;

    fifo_if   #(.DATA_WIDTH(DW))                     fifo_bus ();
    dp_ram_if #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH))  ram_bus ();

    fifo_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .n_rst (n_rst),
        .fifo  (fifo_bus.fifo),
        .ram   (ram_bus.sys),
        .count (count)
    );

    dp_ram #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH)) u_ram (
        .clk (clk),
        .ram (ram_bus.ram)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  model_q[$];
    logic [7:0]  exp_dout   = 8'h00;
    bit          dout_valid = 1'b0;
    int unsigned wr_total   = 0;
    int unsigned rd_total   = 0;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        int unsigned n;
        n = model_q.size();
        chk({tag, "_count"}, count, n);
        chk({tag, "_empty"}, fifo_bus.empty, (n == 0) ? 1 : 0);
        chk({tag, "_full"},  fifo_bus.full,  (n == DEPTH) ? 1 : 0);
        chk({tag, "_flags_excl"}, fifo_bus.full & fifo_bus.empty, 0);
        if (dout_valid) chk({tag, "_dout"}, fifo_bus.data_out, exp_dout);
    endtask

    // One clock of stimulus; accept decisions come from the model's occupancy.
    task automatic step(input bit wr, input bit rd, input logic [7:0] d);
        bit wa;
        bit ra;
        fifo_bus.wr_en   = wr;
        fifo_bus.rd_en   = rd;
        fifo_bus.data_in = d;
        wa = wr && (model_q.size() < DEPTH);
        ra = rd && (model_q.size() != 0);
        #1;
        chk("ram_wr_en", ram_bus.wr_en, wa ? 1 : 0);
        chk("ram_rd_en", ram_bus.rd_en, ra ? 1 : 0);
        if (wa) begin
            chk("ram_wr_addr", ram_bus.wr_addr, wr_total % DEPTH);
            chk("ram_wr_data", ram_bus.data_in, d);
        end
        if (ra) chk("ram_rd_addr", ram_bus.rd_addr, rd_total % DEPTH);
        @(posedge clk);
        if (ra) begin
            exp_dout   = model_q.pop_front();
            dout_valid = 1'b1;
            rd_total++;
        end
        if (wa) begin
            model_q.push_back(d);
            wr_total++;
        end
        #1;
        check_state("step");
    endtask

    initial begin
        n_rst            = 1'b0;
        fifo_bus.wr_en   = 1'b0;
        fifo_bus.rd_en   = 1'b0;
        fifo_bus.data_in = '0;
        #12;
        chk("rst_count",   count, 0);
        chk("rst_empty",   fifo_bus.empty, 1);
        chk("rst_full",    fifo_bus.full, 0);
        chk("rst_wr_en",   ram_bus.wr_en, 0);
        chk("rst_rd_en",   ram_bus.rd_en, 0);
        chk("rst_wr_addr", ram_bus.wr_addr, 0);
        chk("rst_rd_addr", ram_bus.rd_addr, 0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Reads on an empty FIFO are ignored.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
        chk("idle_rd_addr", ram_bus.rd_addr, 0);

        // Fill/drain passes, including a dropped write at full and wrap checks.
        for (int p = 0; p < 4; p++) begin
            for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(p * 16 + i));
            chk("fill_full", fifo_bus.full, 1);
            chk("wr_wrap_bit", u_dut.wr_ptr[PTR_W-1], (wr_total / DEPTH) % 2);
            step(1'b1, 1'b0, 8'hFF);
            for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
            chk("drain_empty", fifo_bus.empty, 1);
            chk("rd_wrap_bit", u_dut.rd_ptr[PTR_W-1], (rd_total / DEPTH) % 2);
        end

        // Simultaneous read/write at mid occupancy.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'(8'h50 + i));
            chk("simul_count4", count, 4);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);

        // Both at empty: only the write lands, data_out untouched.
        step(1'b1, 1'b1, 8'h5A);
        chk("empty_both_count", count, 1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        // Both at full: only the read lands, 0xEE must never come out.
        step(1'b1, 1'b1, 8'hEE);
        chk("full_both_count", count, 7);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("no_ee", (fifo_bus.data_out == 8'hEE) ? 1 : 0, 0);
        end

        // Async reset between edges with five entries queued.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
        fifo_bus.wr_en = 1'b0;
        fifo_bus.rd_en = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", fifo_bus.empty, 1);
        chk("arst_full",  fifo_bus.full, 0);
        model_q.delete();
        wr_total = 0;
        rd_total = 0;
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b1, 8'h00);
        chk("arst_readback", fifo_bus.data_out, 8'hAA);

        // Randomised traffic with phases biased toward filling or draining.
        for (int i = 0; i < 2000; i++) begin
            int unsigned pw;
            int unsigned pr;
            case ((i / 100) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 60; pr = 60; end
            endcase
            step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
